// File: rtl/sc_regbank_pkg.sv
// Shared encodings for the point-type register shift bank.
package sc_regbank_pkg;

  localparam int unsigned MODEWIDTH = 2;

  localparam logic [MODEWIDTH-1:0] MODE_HOLD = 2'b00;
  localparam logic [MODEWIDTH-1:0] MODE_ROTL = 2'b01;
  localparam logic [MODEWIDTH-1:0] MODE_ROTR = 2'b10;
  localparam logic [MODEWIDTH-1:0] MODE_SHL  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } bankState_t;

endpackage

// File: rtl/sc_tick_prescaler.sv
// Auto-step timer: counts 0..period-1 and flags the last count; period 0 disables it.
module sc_tick_prescaler #(
  parameter int unsigned TICKWIDTH = 16
) (
  input  logic                 SC_TickPRESCALER_CLOCK_50,
  input  logic                 SC_TickPRESCALER_RESET_InHigh,
  input  logic                 SC_TickPRESCALER_enable_In,
  input  logic [TICKWIDTH-1:0] SC_TickPRESCALER_period_InBUS,
  output logic                 SC_TickPRESCALER_tick_Out_c
);

  logic [TICKWIDTH-1:0] cntQ;
  logic [TICKWIDTH-1:0] cntNext;
  logic [TICKWIDTH-1:0] lastCnt;
  logic                 periodOn;

  assign periodOn = (SC_TickPRESCALER_period_InBUS != '0);
  assign lastCnt  = SC_TickPRESCALER_period_InBUS - TICKWIDTH'(1);

  // A shrunk period leaves cnt above the new last count; >= forces a wrap without a tick.
  always_comb begin
    cntNext                     = cntQ;
    SC_TickPRESCALER_tick_Out_c = 1'b0;
    if (SC_TickPRESCALER_enable_In) begin
      if (!periodOn) begin
        cntNext = '0;
      end else if (cntQ >= lastCnt) begin
        cntNext                     = '0;
        SC_TickPRESCALER_tick_Out_c = (cntQ == lastCnt);
      end else begin
        cntNext = cntQ + TICKWIDTH'(1);
      end
    end
  end

  always_ff @(posedge SC_TickPRESCALER_CLOCK_50) begin
    if (SC_TickPRESCALER_RESET_InHigh) cntQ <= '0;
    else                               cntQ <= cntNext;
  end

endmodule

// File: rtl/sc_reg_shiftbank.sv
// Bank of ROWS point-type registers with clear, addressed load, burst load and
// rotate/shift stepping (manual or timer-driven).
module sc_reg_shiftbank
  import sc_regbank_pkg::*;
#(
  parameter int unsigned          DATAWIDTH  = 8,
  parameter int unsigned          ROWS       = 4,
  parameter int unsigned          ADDRWIDTH  = 2,
  parameter int unsigned          TICKWIDTH  = 16,
  parameter logic [DATAWIDTH-1:0] INIT_VALUE = DATAWIDTH'(8'h00)
) (
  input  logic                      SC_RegSHIFTBANK_CLOCK_50,
  input  logic                      SC_RegSHIFTBANK_RESET_InHigh,
  input  logic                      SC_RegSHIFTBANK_clear_InLow,
  input  logic                      SC_RegSHIFTBANK_load_InLow,
  input  logic [ADDRWIDTH-1:0]      SC_RegSHIFTBANK_loadaddr_InBUS,
  input  logic [DATAWIDTH-1:0]      SC_RegSHIFTBANK_loaddata_InBUS,
  input  logic [MODEWIDTH-1:0]      SC_RegSHIFTBANK_mode_In,
  input  logic                      SC_RegSHIFTBANK_fill_In,
  input  logic                      SC_RegSHIFTBANK_step_In,
  input  logic [TICKWIDTH-1:0]      SC_RegSHIFTBANK_period_InBUS,
  input  logic                      SC_RegSHIFTBANK_bstart_In,
  input  logic                      SC_RegSHIFTBANK_bvalid_In,
  input  logic [DATAWIDTH-1:0]      SC_RegSHIFTBANK_bdata_InBUS,
  output logic                      SC_RegSHIFTBANK_bready_Out,
  output logic                      SC_RegSHIFTBANK_busy_Out,
  output logic                      SC_RegSHIFTBANK_stepped_Out,
  output logic [ROWS*DATAWIDTH-1:0] SC_RegSHIFTBANK_data_OutBUS
);

  localparam logic [ADDRWIDTH-1:0] LASTROW = ADDRWIDTH'(ROWS - 1);

  bankState_t           stateQ, stateNext;
  logic [ADDRWIDTH-1:0] ptrQ, ptrNext;
  logic                 busyQ;
  logic                 steppedQ;
  logic                 burstWr;
  logic                 clearAct;
  logic                 loadReq;
  logic                 autoTick;
  logic                 stepEvt;

  assign clearAct = ~SC_RegSHIFTBANK_clear_InLow;
  assign loadReq  = ~SC_RegSHIFTBANK_load_InLow && (stateQ == ST_IDLE);

  // A step only counts when it actually alters rows and nothing higher-priority wins.
  assign stepEvt = (SC_RegSHIFTBANK_step_In || autoTick) && (stateQ == ST_IDLE) &&
                   !clearAct && !loadReq && (SC_RegSHIFTBANK_mode_In != MODE_HOLD);

  sc_tick_prescaler #(.TICKWIDTH(TICKWIDTH)) u_tick (
    .SC_TickPRESCALER_CLOCK_50     (SC_RegSHIFTBANK_CLOCK_50),
    .SC_TickPRESCALER_RESET_InHigh (SC_RegSHIFTBANK_RESET_InHigh),
    .SC_TickPRESCALER_enable_In    (stateQ == ST_IDLE),
    .SC_TickPRESCALER_period_InBUS (SC_RegSHIFTBANK_period_InBUS),
    .SC_TickPRESCALER_tick_Out_c   (autoTick)
  );

  // Burst FSM next-state; clear aborts any burst in progress.
  always_comb begin
    stateNext = stateQ;
    ptrNext   = ptrQ;
    burstWr   = 1'b0;
    if (clearAct) begin
      stateNext = ST_IDLE;
      ptrNext   = '0;
    end else begin
      case (stateQ)
        ST_IDLE: begin
          if (SC_RegSHIFTBANK_bstart_In) begin
            stateNext = ST_BURST;
            ptrNext   = '0;
          end
        end
        ST_BURST: begin
          if (SC_RegSHIFTBANK_bvalid_In) begin
            burstWr = 1'b1;
            if (ptrQ == LASTROW) begin
              stateNext = ST_IDLE;
              ptrNext   = '0;
            end else begin
              ptrNext = ptrQ + ADDRWIDTH'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge SC_RegSHIFTBANK_CLOCK_50) begin
    if (SC_RegSHIFTBANK_RESET_InHigh) begin
      stateQ   <= ST_IDLE;
      ptrQ     <= '0;
      busyQ    <= 1'b0;
      steppedQ <= 1'b0;
    end else begin
      stateQ   <= stateNext;
      ptrQ     <= ptrNext;
      busyQ    <= (stateNext == ST_BURST);
      steppedQ <= stepEvt;
    end
  end

  assign SC_RegSHIFTBANK_bready_Out  = busyQ;
  assign SC_RegSHIFTBANK_busy_Out    = busyQ;
  assign SC_RegSHIFTBANK_stepped_Out = steppedQ;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATAWIDTH-1:0] rowQ;
    logic [DATAWIDTH-1:0] rowNext;
    logic [DATAWIDTH-1:0] shifted;

    always_comb begin
      shifted = rowQ;
      case (SC_RegSHIFTBANK_mode_In)
        MODE_ROTL: shifted = {rowQ[DATAWIDTH-2:0], rowQ[DATAWIDTH-1]};
        MODE_ROTR: shifted = {rowQ[0], rowQ[DATAWIDTH-1:1]};
        MODE_SHL:  shifted = {rowQ[DATAWIDTH-2:0], SC_RegSHIFTBANK_fill_In};
        default:   shifted = rowQ;
      endcase

      rowNext = rowQ;
      if (clearAct)
        rowNext = INIT_VALUE;
      else if (burstWr && (ptrQ == ADDRWIDTH'(r)))
        rowNext = SC_RegSHIFTBANK_bdata_InBUS;
      else if (loadReq && (SC_RegSHIFTBANK_loadaddr_InBUS == ADDRWIDTH'(r)))
        rowNext = SC_RegSHIFTBANK_loaddata_InBUS;
      else if (stepEvt)
        rowNext = shifted;
    end

    always_ff @(posedge SC_RegSHIFTBANK_CLOCK_50) begin
      if (SC_RegSHIFTBANK_RESET_InHigh) rowQ <= '0;
      else                              rowQ <= rowNext;
    end

    assign SC_RegSHIFTBANK_data_OutBUS[r*DATAWIDTH +: DATAWIDTH] = rowQ;
  end

endmodule

// File: tb/tb_sc_reg_shiftbank.sv
// Directed-vector bench for sc_reg_shiftbank (4 rows x 8 bits, 3-bit address).
module tb_sc_reg_shiftbank;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 3;
  localparam int unsigned TW = 16;
  localparam logic [DW-1:0] INITV = 8'h3C;

  logic           clk = 1'b0;
  logic           rst;
  logic           clearN, loadN;
  logic [AW-1:0]  laddr;
  logic [DW-1:0]  ldata;
  logic [1:0]     mode;
  logic           fill, step;
  logic [TW-1:0]  period;
  logic           bstart, bvalid;
  logic [DW-1:0]  bdata;
  logic           bready, busy, stepped;
  logic [NR*DW-1:0] data;

  int vecs = 0;
  int errs = 0;

  sc_reg_shiftbank #(
    .DATAWIDTH(DW), .ROWS(NR), .ADDRWIDTH(AW), .TICKWIDTH(TW), .INIT_VALUE(INITV)
  ) dut (
    .SC_RegSHIFTBANK_CLOCK_50       (clk),
    .SC_RegSHIFTBANK_RESET_InHigh   (rst),
    .SC_RegSHIFTBANK_clear_InLow    (clearN),
    .SC_RegSHIFTBANK_load_InLow     (loadN),
    .SC_RegSHIFTBANK_loadaddr_InBUS (laddr),
    .SC_RegSHIFTBANK_loaddata_InBUS (ldata),
    .SC_RegSHIFTBANK_mode_In        (mode),
    .SC_RegSHIFTBANK_fill_In        (fill),
    .SC_RegSHIFTBANK_step_In        (step),
    .SC_RegSHIFTBANK_period_InBUS   (period),
    .SC_RegSHIFTBANK_bstart_In      (bstart),
    .SC_RegSHIFTBANK_bvalid_In      (bvalid),
    .SC_RegSHIFTBANK_bdata_InBUS    (bdata),
    .SC_RegSHIFTBANK_bready_Out     (bready),
    .SC_RegSHIFTBANK_busy_Out       (busy),
    .SC_RegSHIFTBANK_stepped_Out    (stepped),
    .SC_RegSHIFTBANK_data_OutBUS    (data)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input logic [AW-1:0] a, input logic [DW-1:0] d);
    loadN = 1'b0; laddr = a; ldata = d;
    cyc();
    loadN = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vecs++; if (data !== 32'h0) begin errs++; $display("FAIL reset_data: got %h expected %h", data, 32'h0); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vecs++; if (bready !== 1'b0) begin errs++; $display("FAIL reset_bready: got %b expected 0", bready); end
    vecs++; if (stepped !== 1'b0) begin errs++; $display("FAIL reset_stepped: got %b expected 0", stepped); end
    clearN = 1'b0;
    cyc();
    clearN = 1'b1;
    vecs++; if (data !== {4{8'h3C}}) begin errs++; $display("FAIL clear_data: got %h expected %h", data, {4{8'h3C}}); end
  endtask

  task automatic test_rotl_manual();
    load_row(3'd2, 8'hA5);
    vecs++; if (data !== {8'h3C, 8'hA5, 8'h3C, 8'h3C}) begin errs++; $display("FAIL load_row2: got %h expected 3ca53c3c", data); end
    mode = 2'b01; step = 1'b1;
    cyc();
    step = 1'b0;
    vecs++; if (data !== {8'h78, 8'h4B, 8'h78, 8'h78}) begin errs++; $display("FAIL rotl_data: got %h expected 784b7878", data); end
    vecs++; if (stepped !== 1'b1) begin errs++; $display("FAIL rotl_stepped: got %b expected 1", stepped); end
    cyc();
    vecs++; if (stepped !== 1'b0) begin errs++; $display("FAIL rotl_pulse_end: got %b expected 0", stepped); end
    vecs++; if (data !== {8'h78, 8'h4B, 8'h78, 8'h78}) begin errs++; $display("FAIL rotl_hold: got %h expected 784b7878", data); end
    mode = 2'b00;
  endtask

  task automatic test_auto_rotr();
    for (int r = 0; r < 4; r++) load_row(AW'(r), 8'h81);
    vecs++; if (data !== {4{8'h81}}) begin errs++; $display("FAIL auto_preload: got %h expected 81818181", data); end
    mode = 2'b10; period = 16'd3;
    cyc(); cyc();
    vecs++; if (data !== {4{8'h81}}) begin errs++; $display("FAIL auto_early: got %h expected 81818181", data); end
    cyc();
    vecs++; if (data !== {4{8'hC0}}) begin errs++; $display("FAIL auto_tick1: got %h expected c0c0c0c0", data); end
    vecs++; if (stepped !== 1'b1) begin errs++; $display("FAIL auto_stepped1: got %b expected 1", stepped); end
    cyc();
    vecs++; if (stepped !== 1'b0) begin errs++; $display("FAIL auto_gap: got %b expected 0", stepped); end
    cyc(); cyc();
    vecs++; if (data !== {4{8'h60}}) begin errs++; $display("FAIL auto_tick2: got %h expected 60606060", data); end
    period = 16'd0; mode = 2'b00;
    cyc();
  endtask

  task automatic test_burst();
    bstart = 1'b1;
    cyc();
    bstart = 1'b0;
    vecs++; if ({busy, bready} !== 2'b11) begin errs++; $display("FAIL burst_enter: got %b expected 11", {busy, bready}); end
    bvalid = 1'b1; bdata = 8'h11; cyc();
    bdata = 8'h22; cyc();
    // gap: step and load requests must be ignored while bursting
    bvalid = 1'b0; step = 1'b1; mode = 2'b01; loadN = 1'b0; laddr = 3'd0; ldata = 8'hFF;
    cyc();
    step = 1'b0; mode = 2'b00; loadN = 1'b1;
    vecs++; if (data !== {8'h60, 8'h60, 8'h22, 8'h11}) begin errs++; $display("FAIL burst_gap_data: got %h expected 60602211", data); end
    vecs++; if ({busy, stepped} !== 2'b10) begin errs++; $display("FAIL burst_gap_flags: got %b expected 10", {busy, stepped}); end
    bvalid = 1'b1; bdata = 8'h33; cyc();
    bdata = 8'h44; cyc();
    bvalid = 1'b0;
    vecs++; if (data !== {8'h44, 8'h33, 8'h22, 8'h11}) begin errs++; $display("FAIL burst_data: got %h expected 44332211", data); end
    vecs++; if ({busy, bready} !== 2'b00) begin errs++; $display("FAIL burst_exit: got %b expected 00", {busy, bready}); end
  endtask

  task automatic test_clear_mid_burst();
    bstart = 1'b1; cyc(); bstart = 1'b0;
    bvalid = 1'b1; bdata = 8'h55; cyc();
    bdata = 8'h66; cyc();
    clearN = 1'b0; bdata = 8'h77; cyc();
    clearN = 1'b1; bvalid = 1'b0;
    vecs++; if (data !== {4{8'h3C}}) begin errs++; $display("FAIL abort_data: got %h expected 3c3c3c3c", data); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b expected 0", busy); end
    bstart = 1'b1; cyc(); bstart = 1'b0;
    bvalid = 1'b1; bdata = 8'h99; cyc();
    bvalid = 1'b0;
    vecs++; if (data !== {8'h3C, 8'h3C, 8'h3C, 8'h99}) begin errs++; $display("FAIL restart_row0: got %h expected 3c3c3c99", data); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL restart_busy: got %b expected 1", busy); end
    bvalid = 1'b1; bdata = 8'hAA; cyc();
    bdata = 8'hBB; cyc();
    bdata = 8'hCC; cyc();
    bvalid = 1'b0;
    vecs++; if (data !== {8'hCC, 8'hBB, 8'hAA, 8'h99}) begin errs++; $display("FAIL restart_data: got %h expected ccbbaa99", data); end
  endtask

  task automatic test_shl_load_priority();
    mode = 2'b11; fill = 1'b1; step = 1'b1;
    load_row(3'd1, 8'hF0);
    step = 1'b0;
    vecs++; if (data !== {8'hCC, 8'hBB, 8'hF0, 8'h99}) begin errs++; $display("FAIL load_over_step: got %h expected ccbbf099", data); end
    vecs++; if (stepped !== 1'b0) begin errs++; $display("FAIL load_over_step_flag: got %b expected 0", stepped); end
    step = 1'b1; cyc(); step = 1'b0;
    vecs++; if (data !== {8'h99, 8'h77, 8'hE1, 8'h33}) begin errs++; $display("FAIL shl_fill: got %h expected 9977e133", data); end
    vecs++; if (stepped !== 1'b1) begin errs++; $display("FAIL shl_stepped: got %b expected 1", stepped); end
    load_row(3'd5, 8'h00);
    vecs++; if (data !== {8'h99, 8'h77, 8'hE1, 8'h33}) begin errs++; $display("FAIL load_oob: got %h expected 9977e133", data); end
    mode = 2'b00; step = 1'b1; cyc(); step = 1'b0;
    vecs++; if ({data, stepped} !== {8'h99, 8'h77, 8'hE1, 8'h33, 1'b0}) begin errs++; $display("FAIL hold_step: got %h/%b expected 9977e133/0", data, stepped); end
    // manual and auto tick in the same cycle give one step
    mode = 2'b01; period = 16'd1; step = 1'b1; cyc();
    period = 16'd0; step = 1'b0; mode = 2'b00;
    vecs++; if (data !== {8'h33, 8'hEE, 8'hC3, 8'h66}) begin errs++; $display("FAIL dual_step: got %h expected 33eec366", data); end
    vecs++; if (stepped !== 1'b1) begin errs++; $display("FAIL dual_stepped: got %b expected 1", stepped); end
    cyc();
    vecs++; if ({data, stepped} !== {8'h33, 8'hEE, 8'hC3, 8'h66, 1'b0}) begin errs++; $display("FAIL dual_after: got %h/%b expected 33eec366/0", data, stepped); end
  endtask

  initial begin
    rst = 1'b1; clearN = 1'b1; loadN = 1'b1; laddr = '0; ldata = '0;
    mode = 2'b00; fill = 1'b0; step = 1'b0; period = '0;
    bstart = 1'b0; bvalid = 1'b0; bdata = '0;
    #2;
    test_reset();
    test_rotl_manual();
    test_auto_rotr();
    test_burst();
    test_clear_mid_burst();
    test_shl_load_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
